// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART receive path: FSM encoding,
// register bit positions and the baud divisor helper.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit before stop).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    // STATUS register bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_OVR     = 3;
    localparam int STAT_FRM     = 4;
    localparam int STAT_PAR     = 5;
    localparam int STAT_CNT_LSB = 8;

    // DATA register valid bit position (byte sits in [7:0])
    localparam int DATA_VALID_BIT = 8;

    // Clock cycles per bit period.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Serial deframer: 2-flop synchronizer, baud counter and reception FSM.
// Emits a one-cycle byte_valid pulse on the cycle after a good stop sample.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err_p,
    output logic       parity_err_p,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic            sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            bv_q, bv_d, fe_q, fe_d, pe_q, pe_d;
`ifdef UART_RX_PARITY_EN
    logic            pbad_q, pbad_d;
`endif

    // State and datapath registers; reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            bv_q      <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_q    <= 1'b0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            rx_prev_q <= rx_prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            bv_q      <= bv_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
`ifdef UART_RX_PARITY_EN
            pbad_q    <= pbad_d;
`endif
        end
    end

    // Next-state logic: synchronize, detect start edge, sample mid-bit.
    always_comb begin
        sync1_d   = rx_in;
        sync2_d   = sync1_q;
        rx_prev_d = sync2_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        bv_d      = 1'b0;
        fe_d      = 1'b0;
        pe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_d    = pbad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !sync2_q) begin
                    state_d = ST_START;
                    cnt_d   = HALF;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (sync2_q) begin
                        state_d = ST_IDLE;          // false start
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = LAST;
                        bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                        pbad_d  = 1'b0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = LAST;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == '0) begin
                    // Even parity: the parity bit equals the XOR of the data bits.
                    pbad_d  = (sync2_q != ^shift_q);
                    pe_d    = (sync2_q != ^shift_q);
                    state_d = ST_STOP;
                    cnt_d   = LAST;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (sync2_q) begin
`ifdef UART_RX_PARITY_EN
                        bv_d = !pbad_q;
`else
                        bv_d = 1'b1;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_BREAK: begin
                if (sync2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign byte_valid   = bv_q;
    assign rx_byte      = shift_q;
    assign frame_err_p  = fe_q;
    assign parity_err_p = pe_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_rx_mmio.sv
// MMIO UART receive block: deframer core, RX FIFO, sticky error flags and
// the DATA/STATUS register mux on sys_bus.
// Optional feature macro: UART_RX_PARITY_EN (parity_err is 0 when undefined).
//
// Bus strobe semantics: a DATA pop happens only on the rising edge of
// (bus_ren & ~bus_sel); a STATUS write-1-to-clear happens only on the rising
// edge of (bus_wen & bus_sel). Holding a strobe acts once. mmio_rdata is
// combinational from bus_sel and always shows the pre-pop FIFO head.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_in,
    input  logic        bus_ren,
    input  logic        bus_sel,
    input  logic        bus_wen,
    input  logic [31:0] bus_wdata,
    output logic [31:0] mmio_rdata,
    output logic        rx_irq
);

    logic             byte_valid, frame_err_p, parity_err_p, rx_busy;
    logic [7:0]       rx_byte;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0] count_q, count_d;
    logic             ren_prev_q, ren_prev_d, wen_prev_q, wen_prev_d;
    logic             ovr_q, ovr_d, frm_q, frm_d, par_q, par_d;
    logic             empty, full, rd_stb, wr_stb, pop, push, clr_stb;
    logic [31:0]      status_w;
    logic             unused_wdata;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .byte_valid   (byte_valid),
        .rx_byte      (rx_byte),
        .frame_err_p  (frame_err_p),
        .parity_err_p (parity_err_p),
        .busy         (rx_busy)
    );

    assign empty   = (count_q == '0);
    assign full    = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
    assign rd_stb  = bus_ren & ~bus_sel;
    assign wr_stb  = bus_wen & bus_sel;
    assign pop     = rd_stb & ~ren_prev_q & ~empty;
    assign push    = byte_valid & ~full;
    assign clr_stb = wr_stb & ~wen_prev_q;
    assign unused_wdata = ^{bus_wdata[31:6], bus_wdata[2:0]};

    // FIFO pointers, count, strobe edge detectors and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ren_prev_q <= 1'b0;
            wen_prev_q <= 1'b0;
            ovr_q      <= 1'b0;
            frm_q      <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ren_prev_q <= ren_prev_d;
            wen_prev_q <= wen_prev_d;
            ovr_q      <= ovr_d;
            frm_q      <= frm_d;
            par_q      <= par_d;
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_byte;
        end
    end

    // Pointer/count update and flag set/clear (a set beats a same-cycle clear).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ren_prev_d = rd_stb;
        wen_prev_d = wr_stb;
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
            default: count_d = count_q;
        endcase
        ovr_d = (byte_valid & full) | (ovr_q & ~(clr_stb & bus_wdata[STAT_OVR]));
        frm_d = frame_err_p         | (frm_q & ~(clr_stb & bus_wdata[STAT_FRM]));
        par_d = parity_err_p        | (par_q & ~(clr_stb & bus_wdata[STAT_PAR]));
    end

    // Register read mux.
    always_comb begin
        status_w = '0;
        status_w[STAT_BUSY]  = rx_busy;
        status_w[STAT_EMPTY] = empty;
        status_w[STAT_FULL]  = full;
        status_w[STAT_OVR]   = ovr_q;
        status_w[STAT_FRM]   = frm_q;
        status_w[STAT_PAR]   = par_q;
        status_w[STAT_CNT_LSB +: 8] = 8'(count_q);
        mmio_rdata = '0;
        if (bus_sel) begin
            mmio_rdata = status_w;
        end else if (!empty) begin
            mmio_rdata[DATA_VALID_BIT] = 1'b1;
            mmio_rdata[7:0]            = mem_q[rd_ptr_q];
        end
    end

    assign rx_irq = !empty | ovr_q | frm_q | par_q;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Bench for uart_rx_mmio at CLK_FREQ=1 MHz, BAUD=100 kHz (10 clocks per bit).
// Build with +define+UART_RX_PARITY_EN to include the parity case.
module tb_uart_rx_mmio;

    localparam int DIV   = 10;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, rx_in, bus_ren, bus_sel, bus_wen;
    logic [31:0] bus_wdata, mmio_rdata;
    logic        rx_irq;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic        ovr_m, frm_m, par_m;

    uart_rx_mmio #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (DEPTH),
        .FIFO_AW    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .bus_ren    (bus_ren),
        .bus_sel    (bus_sel),
        .bus_wen    (bus_wen),
        .bus_wdata  (bus_wdata),
        .mmio_rdata (mmio_rdata),
        .rx_irq     (rx_irq)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input logic busy);
        logic [31:0] s;
        s      = '0;
        s[0]   = busy;
        s[1]   = (exp_q.size() == 0);
        s[2]   = (exp_q.size() == DEPTH);
        s[3]   = ovr_m;
        s[4]   = frm_m;
        s[5]   = par_m;
        s[15:8] = 8'(exp_q.size());
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        ovr_m = 1'b0;
        frm_m = 1'b0;
        par_m = 1'b0;
    endtask

    // Accepted byte goes to the scoreboard; a byte into a full FIFO is an overrun.
    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() == DEPTH) ovr_m = 1'b1;
        else exp_q.push_back(b);
    endtask

    // Drives start, data (and parity) bits; leaves the stop level on the line.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par);
        @(negedge clk);
        rx_in = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = (^b) ^ bad_par;
        repeat (DIV) @(negedge clk);
`else
        if (bad_par) $display("note: parity not built in");
`endif
        rx_in = stop;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b0);
        repeat (DIV + 4) @(negedge clk);
        model_push(b);
    endtask

    task automatic check_status(input string tag, input logic busy);
        @(negedge clk);
        bus_sel = 1'b1;
        bus_ren = 1'b0;
        #1;
        check(tag, mmio_rdata, exp_status(busy));
        check({tag, "_irq"}, {31'b0, rx_irq},
              {31'b0, (exp_q.size() != 0) || ovr_m || frm_m || par_m});
    endtask

    task automatic read_data(input string tag);
        logic [31:0] e;
        @(negedge clk);
        bus_sel = 1'b0;
        bus_ren = 1'b1;
        #1;
        if (exp_q.size() == 0) begin
            e = 32'h0;
        end else begin
            e = {23'b0, 1'b1, exp_q.pop_front()};
        end
        check(tag, mmio_rdata, e);
        @(negedge clk);
        bus_ren = 1'b0;
    endtask

    task automatic write_status(input logic [31:0] w);
        @(negedge clk);
        bus_sel   = 1'b1;
        bus_wen   = 1'b1;
        bus_wdata = w;
        @(negedge clk);
        bus_wen   = 1'b0;
        bus_wdata = '0;
        if (w[3]) ovr_m = 1'b0;
        if (w[4]) frm_m = 1'b0;
        if (w[5]) par_m = 1'b0;
    endtask

    initial begin
        logic found;
        rst = 1'b1; rx_in = 1'b1; bus_ren = 1'b0; bus_sel = 1'b0;
        bus_wen = 1'b0; bus_wdata = '0;
        ovr_m = 1'b0; frm_m = 1'b0; par_m = 1'b0;
        do_reset();
        check_status("reset_status", 1'b0);

        // 1: single byte
        send_byte(8'hA5);
        check_status("t1_status", 1'b0);
        read_data("t1_data");
        check_status("t1_after", 1'b0);
        read_data("t1_empty_read");

        // 2: held read strobe pops once
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        @(negedge clk);
        bus_sel = 1'b0;
        bus_ren = 1'b1;
        #1;
        check("t2_head", mmio_rdata, {23'b0, 1'b1, exp_q[0]});
        repeat (5) @(negedge clk);
        bus_ren = 1'b0;
        void'(exp_q.pop_front());
        check_status("t2_status", 1'b0);
        read_data("t2_d1");
        read_data("t2_d2");

        // 3: overflow
        for (int i = 0; i <= DEPTH; i++) send_byte(8'(i));
        check_status("t3_full", 1'b0);
        for (int i = 0; i < DEPTH; i++) read_data($sformatf("t3_d%0d", i));
        check_status("t3_drained", 1'b0);
        write_status(32'h08);
        check_status("t3_ovr_clr", 1'b0);

        // 4: glitch, then framing error with held-low line
        @(negedge clk);
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (30) @(negedge clk);
        check_status("t4_glitch", 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        repeat (DIV + 5) @(negedge clk);
        frm_m = 1'b1;
        check_status("t4_break", 1'b1);
        repeat (30) @(negedge clk);
        check_status("t4_break_hold", 1'b1);
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        check_status("t4_idle", 1'b0);
        write_status(32'h10);
        check_status("t4_frm_clr", 1'b0);

        // 5: reset during data bit 4
        send_byte(8'h77);
        @(negedge clk);
        rx_in = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_in = 1'b1;
            repeat (DIV) @(negedge clk);
        end
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        check_status("t5_busy", 1'b1);
        do_reset();
        check_status("t5_reset", 1'b0);
        send_byte(8'h3C);
        read_data("t5_data");

        // 6: pop and push in the same cycle
        send_byte(8'h41);
        send_byte(8'h42);
        send_frame(8'h43, 1'b1, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 3 * DIV && !found; k++) begin
            @(negedge clk);
            bus_sel = 1'b1;
            bus_ren = 1'b0;
            #1;
            if (mmio_rdata[0] == 1'b0) found = 1'b1;
        end
        check("t6_busy_drop", {31'b0, found}, 32'h1);
        if (found) begin
            bus_sel = 1'b0;
            bus_ren = 1'b1;
            #1;
            check("t6_head", mmio_rdata, {23'b0, 1'b1, exp_q[0]});
            void'(exp_q.pop_front());
            exp_q.push_back(8'h43);
            @(negedge clk);
            bus_ren = 1'b0;
        end else begin
            exp_q.push_back(8'h43);
        end
        check_status("t6_status", 1'b0);
        read_data("t6_d1");
        read_data("t6_d2");

`ifdef UART_RX_PARITY_EN
        // 7: bad parity
        send_frame(8'h5A, 1'b1, 1'b1);
        repeat (DIV + 4) @(negedge clk);
        par_m = 1'b1;
        check_status("t7_parity", 1'b0);
        write_status(32'h20);
        check_status("t7_par_clr", 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
